// File: rtl/tap_controller_param_if.sv
// JTAG pin-side and data-register-side signals of the parametrised TAP controller.
// slave: the TAP controller itself; master: whatever drives the pins and owns the user DRs.
interface tap_controller_param_if #(
  parameter int IR_WIDTH = 5,
  parameter int NUM_DR   = 2
);
  logic                tms;
  logic                tdi;
  logic                tdo;
  logic                tdo_en;
  logic [NUM_DR-1:0]   dr_tdo;
  logic [NUM_DR-1:0]   dr_sel;
  logic                capture_dr;
  logic                shift_dr;
  logic                update_dr;
  logic [IR_WIDTH-1:0] ir_out;
  logic                tap_rst_n;
  logic [3:0]          state;

  modport slave (
    input  tms, tdi, dr_tdo,
    output tdo, tdo_en, dr_sel, capture_dr, shift_dr, update_dr, ir_out, tap_rst_n, state
  );

  modport master (
    output tms, tdi, dr_tdo,
    input  tdo, tdo_en, dr_sel, capture_dr, shift_dr, update_dr, ir_out, tap_rst_n, state
  );
endinterface

// File: rtl/tap_controller_param.sv
// IEEE 1149.1 TAP controller: 16-state FSM, IR, BYPASS, optional IDCODE, user-DR select, negedge TDO.
// Build option: define TAP_IDCODE_EN to include the IDCODE register (opcode 1, reset instruction).
module tap_controller_param #(
  parameter int          IR_WIDTH   = 5,
  parameter int          NUM_DR     = 2,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5679
) (
  input logic                   tck,
  input logic                   trst,
  tap_controller_param_if.slave bus
);

  localparam logic [3:0] S_EX2DR = 4'h0;
  localparam logic [3:0] S_EX1DR = 4'h1;
  localparam logic [3:0] S_SDR   = 4'h2;
  localparam logic [3:0] S_PDR   = 4'h3;
  localparam logic [3:0] S_SELIR = 4'h4;
  localparam logic [3:0] S_UDR   = 4'h5;
  localparam logic [3:0] S_CDR   = 4'h6;
  localparam logic [3:0] S_SELDR = 4'h7;
  localparam logic [3:0] S_EX2IR = 4'h8;
  localparam logic [3:0] S_EX1IR = 4'h9;
  localparam logic [3:0] S_SIR   = 4'hA;
  localparam logic [3:0] S_PIR   = 4'hB;
  localparam logic [3:0] S_RTI   = 4'hC;
  localparam logic [3:0] S_UIR   = 4'hD;
  localparam logic [3:0] S_CIR   = 4'hE;
  localparam logic [3:0] S_TLR   = 4'hF;

  localparam logic [IR_WIDTH-1:0] IR_BYPASS  = {IR_WIDTH{1'b1}};
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
`ifdef TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] RESET_IR   = IR_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RESET_IR   = IR_BYPASS;
`endif

  // Reject parameter sets that would make the opcode map or IDCODE format invalid.
  if (IR_WIDTH < 2) begin : g_chk_ir_width
    $error("tap_controller_param: IR_WIDTH must be at least 2");
  end
  if (NUM_DR < 1 || NUM_DR > (1 << IR_WIDTH) - 3) begin : g_chk_num_dr
    $error("tap_controller_param: NUM_DR out of range for IR_WIDTH");
  end
  if (IDCODE_VAL[0] != 1'b1) begin : g_chk_idcode
    $error("tap_controller_param: IDCODE_VAL bit 0 must be 1");
  end

  logic [3:0]          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_sr_q;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                bypass_q;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  logic                capture_q, capture_d;
  logic                shift_q, shift_d;
  logic                update_q, update_d;
  logic                tap_rst_n_q, tap_rst_n_d;

  logic [NUM_DR-1:0]   dr_sel;
  logic                user_sel;
  logic                user_tdo;
  logic                idcode_sel;
  logic                bypass_sel;
  logic                idcode_tdo;

  // ------------------------------------------------------------------
  // TAP state machine
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TLR:   state_d = bus.tms ? S_TLR   : S_RTI;
      S_RTI:   state_d = bus.tms ? S_SELDR : S_RTI;
      S_SELDR: state_d = bus.tms ? S_SELIR : S_CDR;
      S_CDR:   state_d = bus.tms ? S_EX1DR : S_SDR;
      S_SDR:   state_d = bus.tms ? S_EX1DR : S_SDR;
      S_EX1DR: state_d = bus.tms ? S_UDR   : S_PDR;
      S_PDR:   state_d = bus.tms ? S_EX2DR : S_PDR;
      S_EX2DR: state_d = bus.tms ? S_UDR   : S_SDR;
      S_UDR:   state_d = bus.tms ? S_SELDR : S_RTI;
      S_SELIR: state_d = bus.tms ? S_TLR   : S_CIR;
      S_CIR:   state_d = bus.tms ? S_EX1IR : S_SIR;
      S_SIR:   state_d = bus.tms ? S_EX1IR : S_SIR;
      S_EX1IR: state_d = bus.tms ? S_UIR   : S_PIR;
      S_PIR:   state_d = bus.tms ? S_EX2IR : S_PIR;
      S_EX2IR: state_d = bus.tms ? S_UIR   : S_SIR;
      S_UIR:   state_d = bus.tms ? S_SELDR : S_RTI;
      default: state_d = S_TLR;
    endcase
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state_q <= S_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------
  // Instruction decode: user DR k lives at opcode 2+k, anything unmapped is BYPASS.
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_DR; gi++) begin : g_dr_sel
    assign dr_sel[gi] = (ir_q == IR_WIDTH'(gi + 2));
  end

  assign user_sel = |dr_sel;
  assign user_tdo = |(dr_sel & bus.dr_tdo);

`ifdef TAP_IDCODE_EN
  logic [31:0] idcode_sr_q;

  assign idcode_sel = (ir_q == IR_IDCODE);
  assign idcode_tdo = idcode_sr_q[0];

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      idcode_sr_q <= '0;
    end else if (idcode_sel) begin
      if (state_q == S_CDR) begin
        idcode_sr_q <= IDCODE_VAL;
      end else if (state_q == S_SDR) begin
        idcode_sr_q <= {bus.tdi, idcode_sr_q[31:1]};
      end
    end
  end
`else
  assign idcode_sel = 1'b0;
  assign idcode_tdo = 1'b0;
`endif

  assign bypass_sel = !user_sel && !idcode_sel;

  // ------------------------------------------------------------------
  // Posedge shift stages
  // ------------------------------------------------------------------
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_sr_q <= '0;
    end else if (state_q == S_CIR) begin
      ir_sr_q <= IR_CAPTURE;
    end else if (state_q == S_SIR) begin
      ir_sr_q <= {bus.tdi, ir_sr_q[IR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      bypass_q <= 1'b0;
    end else if (bypass_sel) begin
      if (state_q == S_CDR) begin
        bypass_q <= 1'b0;
      end else if (state_q == S_SDR) begin
        bypass_q <= bus.tdi;
      end
    end
  end

  // ------------------------------------------------------------------
  // Negedge outputs: everything the pins and user DRs see is stable across the next posedge.
  // ------------------------------------------------------------------
  always_comb begin
    tdo_d = 1'b0;
    if (state_q == S_SIR) begin
      tdo_d = ir_sr_q[0];
    end else if (state_q == S_SDR) begin
      if (user_sel) begin
        tdo_d = user_tdo;
      end else if (idcode_sel) begin
        tdo_d = idcode_tdo;
      end else begin
        tdo_d = bypass_q;
      end
    end
  end

  always_comb begin
    ir_d = ir_q;
    if (state_q == S_TLR) begin
      ir_d = RESET_IR;
    end else if (state_q == S_UIR) begin
      ir_d = ir_sr_q;
    end
  end

  assign tdo_en_d    = (state_q == S_SIR) || (state_q == S_SDR);
  assign capture_d   = user_sel && (state_q == S_CDR);
  assign shift_d     = user_sel && (state_q == S_SDR);
  assign update_d    = user_sel && (state_q == S_UDR);
  assign tap_rst_n_d = (state_q != S_TLR);

  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      ir_q        <= RESET_IR;
      tdo_q       <= 1'b0;
      tdo_en_q    <= 1'b0;
      capture_q   <= 1'b0;
      shift_q     <= 1'b0;
      update_q    <= 1'b0;
      tap_rst_n_q <= 1'b0;
    end else begin
      ir_q        <= ir_d;
      tdo_q       <= tdo_d;
      tdo_en_q    <= tdo_en_d;
      capture_q   <= capture_d;
      shift_q     <= shift_d;
      update_q    <= update_d;
      tap_rst_n_q <= tap_rst_n_d;
    end
  end

  assign bus.tdo        = tdo_q;
  assign bus.tdo_en     = tdo_en_q;
  assign bus.dr_sel     = dr_sel;
  assign bus.capture_dr = capture_q;
  assign bus.shift_dr   = shift_q;
  assign bus.update_dr  = update_q;
  assign bus.ir_out     = ir_q;
  assign bus.tap_rst_n  = tap_rst_n_q;
  assign bus.state      = state_q;

endmodule

// File: doc/tap_controller_param.md
# tap_controller_param

Parametrised successor to the team's IEEE 1149.1 TAP controller. It merges the 16-state TAP FSM with an instruction register of configurable width, on-block BYPASS and IDCODE data registers, one-hot select for `NUM_DR` external user data registers, and a registered TDO mux. It sits between the chip JTAG pins and the debug and scan data registers, replacing the separate controller-plus-glue arrangement.

## Interface
- `IR_WIDTH`, default 5: instruction register width; minimum 2.
- `NUM_DR`, default 2: number of external user data registers; range 1 to 2^IR_WIDTH−3.
- `IDCODE_VAL`, default 32'h1234_5679: IDCODE contents; bit 0 must be 1.
- `tck`, input, 1: test clock; the only clock.
- `trst`, input, 1: asynchronous, active-low reset.
- `tms`, input, 1: test mode select, sampled on posedge `tck`.
- `tdi`, input, 1: test data in, sampled on posedge `tck`.
- `tdo`, output, 1: test data out, changes on negedge `tck`.
- `tdo_en`, output, 1: TDO output-driver enable.
- `dr_tdo`, input, NUM_DR: serial outputs (LSB) of the user data registers.
- `dr_sel`, output, NUM_DR: one-hot select of the active user data register; all-zero when none is selected.
- `capture_dr`, `shift_dr`, `update_dr`, output, 1 each: data-register strobes, gated by the decoded instruction.
- `ir_out`, output, IR_WIDTH: current (updated) instruction.
- `tap_rst_n`, output, 1: low while in TLReset.
- `state`, output, 4: current FSM state, for debug.

## Operation
- **State encoding** (4 bits): Exit2DR 0, Exit1DR 1, ShiftDR 2, PauseDR 3, SelectIR 4, UpdateDR 5, CaptureDR 6, SelectDR 7, Exit2IR 8, Exit1IR 9, ShiftIR A, PauseIR B, RunTestIdle C, UpdateIR D, CaptureIR E, TLReset F.
- **Transitions:** standard 1149.1 transitions on `tms`.
- **Instruction decode:**
  - 1 = IDCODE.
  - 2+k = user DR k, for k < NUM_DR.
  - All-ones = BYPASS.
  - Every other code, including 0, decodes as BYPASS.
- **Reset instruction:** IDCODE (see Configuration).
- **IR shift stage:**
  - In CaptureIR, loads {0…0, 2'b01}.
  - In ShiftIR, shifts as {tdi, sr[IR_WIDTH-1:1]}.
  - `ir_out` loads the stage on the negedge in UpdateIR.
  - `ir_out` loads the reset instruction on the negedge in TLReset.
- **BYPASS register:** 1 bit; captures 0 in CaptureDR and loads `tdi` in ShiftDR.
- **IDCODE register:** 32 bits; captures IDCODE_VAL in CaptureDR and shifts right, LSB first, with `tdi` entering at the MSB.
  - Internal registers act only while their instruction is current.
- **TDO mux:**
  - ShiftIR: IR stage[0].
  - ShiftDR: the LSB of the register selected by `ir_out`; for a user DR this is `dr_tdo[k]`.
  - Otherwise: 0.
- **`dr_sel[k]`:** 1 only when `ir_out` decodes to user DR k, independent of FSM state.
- **User-DR strobes:** `capture_dr`, `shift_dr` and `update_dr` assert only when the current instruction is a user DR; they stay 0 under BYPASS and IDCODE.
- **Instruction changes** take effect only at UpdateIR or TLReset. A shift that is aborted through TLReset leaves `ir_out` at the reset instruction.

## Timing
- FSM and all shift stages update on posedge `tck`.
- The following are registered on negedge `tck`, so they are stable across the next posedge:
  - `tdo`, `tdo_en`, `capture_dr`, `shift_dr`, `update_dr`, `tap_rst_n`, `ir_out`.
  - The strobes reflect the state entered at the preceding posedge.
- `dr_sel` is derived combinationally from `ir_out`.
- **`trst` low (asynchronous), immediately:**
  - `state` = F.
  - `ir_out` = reset instruction.
  - IR stage = 0.
  - `tdo` = 0, `tdo_en` = 0.
  - All strobes = 0.
  - `tap_rst_n` = 0.
  - `dr_sel` = 0 without IDCODE.
- **Reset release:** the FSM leaves TLReset at the first posedge after `trst` deasserts with `tms` = 0.
- **Mid-shift reset:** `trst` asserted during ShiftDR or ShiftIR aborts the shift. No update occurs and `ir_out` takes the reset instruction.
- **Forced reset:** five consecutive posedges with `tms` = 1 reach TLReset from any state.
- **Scan latency:** the first TDO bit of a scan is valid after the negedge following entry to Shift*. A BYPASS scan delays data by exactly one `tck`.

## Configuration
- Macro: `TAP_IDCODE_EN`.
- **Defined:**
  - IDCODE register is present.
  - Opcode 1 selects it.
  - The reset instruction is IDCODE.
- **Undefined:**
  - IDCODE register is removed.
  - Opcode 1 decodes as BYPASS.
  - The reset instruction is all-ones (BYPASS), so a DR scan after reset returns a single 0 followed by the delayed `tdi`.

## Test plan
All scenarios use IR_WIDTH=5, NUM_DR=2 and `TAP_IDCODE_EN` defined unless stated otherwise.

- **IDCODE after reset:** pulse `trst` low, go to ShiftDR, shift 32 bits → TDO reads 0x12345679, LSB first. `ir_out` = 5'h01 and `dr_sel` = 0 throughout.
- **IR capture and update:** scan in 5'h1F → TDO shows the captured value 1,0,0,0,0 (LSB first). After UpdateIR, `ir_out` = 5'h1F. A following 9-bit DR scan of 0xA5 reads 0 and then 0xA5, delayed by one cycle.
- **User DR select:** load IR 5'h03 → `dr_sel` = 2'b10. With `dr_tdo[1]` toggling, TDO follows it one negedge later. `capture_dr`, `shift_dr` and `update_dr` each pulse in their states, with `tdo_en` = 1 only during ShiftDR.
- **Illegal opcode:** load 5'h00, then 5'h04 → both decode as BYPASS: `dr_sel` = 0, user strobes stay 0, 1-bit bypass path.
- **Aborts:**
  - Assert `trst` in the middle of a 5'h02 IR scan → immediate TLReset and `ir_out` = 5'h01.
  - From PauseDR, apply `tms` = 1 for 5 `tck` → `state` = F and `tap_rst_n` = 0.
- **Macro undefined:** reset → `ir_out` = 5'h1F. Loading 5'h01 gives a bypass scan.
